// File: rtl/reg_alu.sv
// Datapath slice with a 32 x 16-bit register file and a combinational 16-bit ALU.
// The ALU result drives Q and is also the register file's write data.
module reg_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RF_W_en,
  input  logic [4:0]  RF_W_addr,
  input  logic [4:0]  RF_Ra_addr,
  input  logic [4:0]  RF_Rb_addr,
  input  logic [2:0]  ALU_s0,
  output logic [15:0] Q
);

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'b000,
    OP_ADD    = 3'b001,
    OP_SUB    = 3'b010,
    OP_AND    = 3'b011,
    OP_OR     = 3'b100,
    OP_XOR    = 3'b101,
    OP_NOT_A  = 3'b110,
    OP_PASS_B = 3'b111
  } alu_op_e;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  alu_op_e           alu_op;

  // Combinational read ports: old contents until the write edge lands.
  assign op_a   = rf_q[RF_Ra_addr];
  assign op_b   = rf_q[RF_Rb_addr];
  assign alu_op = alu_op_e'(ALU_s0);

  // ALU; add/sub wrap mod 2^16 with carry/borrow dropped.
  always_comb begin
    Q = '0;
    case (alu_op)
      OP_PASS_A: Q = op_a;
      OP_ADD:    Q = DATA_W'(op_a + op_b);
      OP_SUB:    Q = DATA_W'(op_a - op_b);
      OP_AND:    Q = op_a & op_b;
      OP_OR:     Q = op_a | op_b;
      OP_XOR:    Q = op_a ^ op_b;
      OP_NOT_A:  Q = ~op_a;
      OP_PASS_B: Q = op_b;
      default:   Q = '0;
    endcase
  end

  // Write-back; the register breaks the Q -> rf -> Q path, so accumulate steps once per edge.
  always_comb begin
    rf_d = rf_q;
    if (RF_W_en) begin
      rf_d[RF_W_addr] = Q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

endmodule

// File: tb/tb_reg_alu.sv
// Directed bench for reg_alu: stimulus pushes expected Q into a scoreboard queue,
// an independent monitor samples Q on each observe request and compares.
module tb_reg_alu;

  logic        clk;
  logic        rst_n;
  logic        RF_W_en;
  logic [4:0]  RF_W_addr;
  logic [4:0]  RF_Ra_addr;
  logic [4:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [15:0] Q;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  event      obs_ev;
  int        n_checks = 0;
  int        n_fail   = 0;

  reg_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RF_W_en    (RF_W_en),
    .RF_W_addr  (RF_W_addr),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .Q          (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation per observe request and compares against Q.
  initial begin
    forever begin
      sb_entry_t e;
      @(obs_ev);
      #1;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: observe request with empty scoreboard, Q=%h", Q);
      end else begin
        e = sb_q.pop_front();
        if (Q !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got Q=%h expected %h", e.name, Q, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic expect_q(input string name, input logic [15:0] exp);
    sb_entry_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    -> obs_ev;
    #2;
  endtask

  task automatic set_ops(input logic [4:0] ra, input logic [4:0] rb, input logic [2:0] op);
    RF_Ra_addr = ra;
    RF_Rb_addr = rb;
    ALU_s0     = op;
    #1;
  endtask

  // Advance one rising edge, return just after the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = '0;
    repeat (2) @(negedge clk);

    // 1. reset
    set_ops(5'd1, 5'd2, 3'b001);
    expect_q("rst_add_in_reset", 16'h0000);
    rst_n = 1'b1;
    #1;
    expect_q("rst_add_released", 16'h0000);
    set_ops(5'd0, 5'd2, 3'b110);
    expect_q("rst_not_r0", 16'hFFFF);

    // 2. write-back into r1
    @(negedge clk);
    RF_W_en = 1'b1; RF_W_addr = 5'd1;
    set_ops(5'd0, 5'd2, 3'b110);
    expect_q("wb_not_before_edge", 16'hFFFF);
    step();
    RF_W_en = 1'b0;
    set_ops(5'd1, 5'd2, 3'b000);
    expect_q("wb_r1_read", 16'hFFFF);
    set_ops(5'd0, 5'd2, 3'b000);
    expect_q("wb_r0_untouched", 16'h0000);

    // 3. arithmetic wrap
    set_ops(5'd1, 5'd1, 3'b001);
    expect_q("add_wrap", 16'hFFFE);
    RF_W_en = 1'b1; RF_W_addr = 5'd2;
    step();
    set_ops(5'd0, 5'd1, 3'b010);
    expect_q("sub_wrap", 16'h0001);
    RF_W_addr = 5'd3;
    step();
    RF_W_en = 1'b0;
    set_ops(5'd2, 5'd0, 3'b000);
    expect_q("r2_read", 16'hFFFE);
    set_ops(5'd3, 5'd0, 3'b000);
    expect_q("r3_read", 16'h0001);

    // 4. logic ops on r1=FFFF, r2=FFFE
    set_ops(5'd1, 5'd2, 3'b011);
    expect_q("and", 16'hFFFE);
    set_ops(5'd1, 5'd2, 3'b100);
    expect_q("or", 16'hFFFF);
    set_ops(5'd1, 5'd2, 3'b101);
    expect_q("xor", 16'h0001);
    set_ops(5'd1, 5'd2, 3'b111);
    expect_q("pass_b", 16'hFFFE);
    set_ops(5'd1, 5'd2, 3'b110);
    expect_q("not_a", 16'h0000);
    set_ops(5'd3, 5'd2, 3'b010);
    expect_q("sub_small_minus_big", 16'h0003);

    // 5. accumulate r3 += r3, then gate writes
    @(negedge clk);
    RF_W_en = 1'b1; RF_W_addr = 5'd3;
    set_ops(5'd3, 5'd3, 3'b001);
    expect_q("acc_r3_1", 16'h0002);
    step();
    expect_q("acc_r3_2", 16'h0004);
    step();
    expect_q("acc_r3_4", 16'h0008);
    step();
    expect_q("acc_r3_8", 16'h0010);
    RF_W_en = 1'b0;
    step();
    expect_q("gated_edge1", 16'h0010);
    step();
    expect_q("gated_edge2", 16'h0010);
    set_ops(5'd3, 5'd3, 3'b000);
    expect_q("gated_r3", 16'h0008);

    // 6. async reset mid-operation with writes enabled
    @(negedge clk);
    RF_W_en = 1'b1; RF_W_addr = 5'd3;
    set_ops(5'd3, 5'd3, 3'b001);
    expect_q("pre_reset_acc", 16'h0010);
    rst_n = 1'b0;
    #1;
    expect_q("async_reset_q", 16'h0000);
    RF_W_addr = 5'd5;
    set_ops(5'd0, 5'd0, 3'b110);
    expect_q("in_reset_not", 16'hFFFF);
    step();
    step();
    RF_W_en = 1'b0;
    rst_n   = 1'b1;
    set_ops(5'd5, 5'd0, 3'b000);
    expect_q("no_write_in_reset", 16'h0000);
    for (int i = 0; i < 32; i++) begin
      set_ops(5'(i), 5'(31 - i), 3'b100);
      expect_q($sformatf("cleared_r%0d", i), 16'h0000);
    end

    // first write after release lands on the first rising edge
    RF_W_en = 1'b1; RF_W_addr = 5'd6;
    set_ops(5'd0, 5'd0, 3'b110);
    step();
    RF_W_en = 1'b0;
    set_ops(5'd6, 5'd0, 3'b000);
    expect_q("first_write_after_reset", 16'hFFFF);

    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
